// File: rtl/video_to_fifo_ctrl.sv
// Video capture packer: packs 24-bit RGB pixels into FIFO words and raises one
// AXI write-burst request per active line, with sticky timing-error flags.
module video_to_fifo_ctrl #(
  parameter logic [11:0] H_DISP          = 12'd1920,
  parameter logic [11:0] V_DISP          = 12'd1080,
  parameter int          AXI4_DATA_WIDTH = 128
) (
  input  logic                       video_clk,
  input  logic                       video_rst_n,
  input  logic                       video_vs_in,
  input  logic                       video_hs_in,
  input  logic                       video_de_in,
  input  logic [23:0]                video_data_in,
  output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
  output logic                       fifo_wr_en,
  output logic                       AXI_FULL_BURST_VALID,
  input  logic                       AXI_FULL_BURST_READY,
  output logic                       frame_start,
  output logic [11:0]                line_cnt,
  input  logic                       err_clear,
  output logic                       err_line_len,
  output logic                       err_burst_ovr
);

  localparam int PPW = AXI4_DATA_WIDTH / 32;
  localparam int SW  = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic {S_WAIT_VS, S_ACTIVE} state_t;

  state_t                     state_q, state_d;
  logic                       vs_d1_q, de_d1_q;
  logic [SW-1:0]              shift_cnt_q, shift_cnt_d;
  logic [11:0]                x_cnt_q, x_cnt_d;
  logic [11:0]                line_cnt_q, line_cnt_d;
  logic [AXI4_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [AXI4_DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic                       wr_en_q, wr_en_d;
  logic                       valid_q, valid_d;
  logic                       frame_start_q, frame_start_d;
  logic                       err_len_q, err_len_d;
  logic                       err_ovr_q, err_ovr_d;
  logic                       vs_fall, de_fall, burst_set, len_err_set, ovr_set;

  assign vs_fall = vs_d1_q & ~video_vs_in;
  assign de_fall = de_d1_q & ~video_de_in;

  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    x_cnt_d       = x_cnt_q;
    line_cnt_d    = line_cnt_q;
    acc_d         = acc_q;
    fifo_data_d   = fifo_data_q;
    wr_en_d       = 1'b0;
    frame_start_d = 1'b0;
    burst_set     = 1'b0;
    len_err_set   = 1'b0;

    // A vs fall always restarts the frame, dropping any partial word.
    if (vs_fall) begin
      state_d       = S_ACTIVE;
      line_cnt_d    = '0;
      x_cnt_d       = '0;
      shift_cnt_d   = '0;
      acc_d         = '0;
      frame_start_d = 1'b1;
    end else if (state_q == S_ACTIVE) begin
      if (video_de_in) begin
        for (int l = 0; l < PPW; l++) begin
          if (shift_cnt_q == SW'(l)) begin
            acc_d[AXI4_DATA_WIDTH-32*(l+1) +: 32] = {8'd0, video_data_in};
          end
        end
        if (x_cnt_q != 12'hFFF) x_cnt_d = x_cnt_q + 12'd1;
        if (shift_cnt_q == SW'(PPW-1)) begin
          fifo_data_d = acc_d;
          wr_en_d     = 1'b1;
          acc_d       = '0;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + SW'(1);
        end
      end else if (de_fall) begin
        if (shift_cnt_q != '0) begin
          fifo_data_d = acc_q;
          wr_en_d     = 1'b1;
          len_err_set = 1'b1;
          shift_cnt_d = '0;
          acc_d       = '0;
        end
        if (x_cnt_q != H_DISP) len_err_set = 1'b1;
        x_cnt_d    = '0;
        line_cnt_d = line_cnt_q + 12'd1;
        burst_set  = 1'b1;
        if (line_cnt_q + 12'd1 == V_DISP) state_d = S_WAIT_VS;
      end
    end

    // Request set beats the handshake clear; a set on a stalled request is an overrun.
    ovr_set = burst_set & valid_q & ~AXI_FULL_BURST_READY;
    if (burst_set)                          valid_d = 1'b1;
    else if (valid_q && AXI_FULL_BURST_READY) valid_d = 1'b0;
    else                                    valid_d = valid_q;

    if (len_err_set)    err_len_d = 1'b1;
    else if (err_clear) err_len_d = 1'b0;
    else                err_len_d = err_len_q;

    if (ovr_set)        err_ovr_d = 1'b1;
    else if (err_clear) err_ovr_d = 1'b0;
    else                err_ovr_d = err_ovr_q;
  end

  always_ff @(posedge video_clk or negedge video_rst_n) begin
    if (!video_rst_n) begin
      state_q       <= S_WAIT_VS;
      vs_d1_q       <= 1'b0;
      de_d1_q       <= 1'b0;
      shift_cnt_q   <= '0;
      x_cnt_q       <= '0;
      line_cnt_q    <= '0;
      acc_q         <= '0;
      fifo_data_q   <= '0;
      wr_en_q       <= 1'b0;
      valid_q       <= 1'b0;
      frame_start_q <= 1'b0;
      err_len_q     <= 1'b0;
      err_ovr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      vs_d1_q       <= video_vs_in;
      de_d1_q       <= video_de_in;
      shift_cnt_q   <= shift_cnt_d;
      x_cnt_q       <= x_cnt_d;
      line_cnt_q    <= line_cnt_d;
      acc_q         <= acc_d;
      fifo_data_q   <= fifo_data_d;
      wr_en_q       <= wr_en_d;
      valid_q       <= valid_d;
      frame_start_q <= frame_start_d;
      err_len_q     <= err_len_d;
      err_ovr_q     <= err_ovr_d;
    end
  end

  assign fifo_data_out        = fifo_data_q;
  assign fifo_wr_en           = wr_en_q;
  assign AXI_FULL_BURST_VALID = valid_q;
  assign frame_start          = frame_start_q;
  assign line_cnt             = line_cnt_q;
  assign err_line_len         = err_len_q;
  assign err_burst_ovr        = err_ovr_q;

  logic unused_hs;
  assign unused_hs = video_hs_in;

endmodule

// File: tb/tb_video_to_fifo_ctrl.sv
// Directed bench for video_to_fifo_ctrl with H_DISP=8, V_DISP=2, 128-bit words.
module tb_video_to_fifo_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [23:0]  data = '0;
  logic [127:0] fifo_data;
  logic         wr_en, valid, ready = 1'b1, fs, err_clr = 1'b0, err_len, err_ovr;
  logic [11:0]  lcnt;

  video_to_fifo_ctrl #(.H_DISP(12'd8), .V_DISP(12'd2), .AXI4_DATA_WIDTH(128)) dut (
    .video_clk(clk), .video_rst_n(rst_n), .video_vs_in(vs), .video_hs_in(hs),
    .video_de_in(de), .video_data_in(data), .fifo_data_out(fifo_data), .fifo_wr_en(wr_en),
    .AXI_FULL_BURST_VALID(valid), .AXI_FULL_BURST_READY(ready), .frame_start(fs),
    .line_cnt(lcnt), .err_clear(err_clr), .err_line_len(err_len), .err_burst_ovr(err_ovr)
  );

  always #5 clk = ~clk;

  logic [127:0] wq[$];
  int vcnt = 0, fscnt = 0;
  always @(negedge clk) begin
    if (wr_en) wq.push_back(fifo_data);
    if (valid) vcnt <= vcnt + 1;
    if (fs) fscnt <= fscnt + 1;
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic vs_pulse();
    vs = 1'b1; tick(); tick();
    vs = 1'b0; tick();
  endtask

  task automatic send_pixels(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      de = 1'b1; data = 24'(base + i); tick();
    end
  endtask

  task automatic send_line(input int n, input int base);
    send_pixels(n, base);
    de = 1'b0; data = '0; tick();
    tick(); tick();
  endtask

  task automatic pulse_clear();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  typedef struct {
    int           npix;
    int           nwr;
    logic [127:0] w0;
    logic [127:0] w1;
    logic         err;
  } vec_t;
  vec_t tbl[5];

  int idx, v0, f0;

  initial begin
    tbl[0] = '{8, 2, {32'h1, 32'h2, 32'h3, 32'h4}, {32'h5, 32'h6, 32'h7, 32'h8}, 1'b0};
    tbl[1] = '{6, 2, {32'h1, 32'h2, 32'h3, 32'h4}, {32'h5, 32'h6, 32'h0, 32'h0}, 1'b1};
    tbl[2] = '{3, 1, {32'h1, 32'h2, 32'h3, 32'h0}, 128'h0,                       1'b1};
    tbl[3] = '{4, 1, {32'h1, 32'h2, 32'h3, 32'h4}, 128'h0,                       1'b1};
    tbl[4] = '{9, 3, {32'h1, 32'h2, 32'h3, 32'h4}, {32'h5, 32'h6, 32'h7, 32'h8}, 1'b1};

    tick(); tick();
    check("reset_wr_en", 128'(wr_en), 128'h0);
    check("reset_data", fifo_data, 128'h0);
    check("reset_valid", 128'(valid), 128'h0);
    check("reset_line_cnt", 128'(lcnt), 128'h0);
    rst_n = 1'b1; tick();

    // Pixels before any vs fall are ignored.
    send_line(8, 1);
    check("pre_vs_writes", 128'(wq.size()), 128'h0);
    check("pre_vs_valid", 128'(vcnt), 128'h0);
    check("pre_vs_line_cnt", 128'(lcnt), 128'h0);

    // Two full frames, READY tied high.
    f0 = fscnt;
    for (int f = 0; f < 2; f++) begin
      idx = wq.size(); v0 = vcnt;
      vs_pulse();
      send_line(8, 1);
      send_line(8, 9);
      check("frame_writes", 128'(wq.size() - idx), 128'd4);
      check("frame_word0", wq[idx], {32'h1, 32'h2, 32'h3, 32'h4});
      check("frame_word3", wq[idx+3], {32'hd, 32'he, 32'hf, 32'h10});
      check("frame_valid_cycles", 128'(vcnt - v0), 128'd2);
      check("frame_line_cnt", 128'(lcnt), 128'd2);
    end
    check("frame_start_count", 128'(fscnt - f0), 128'd2);
    idx = wq.size();
    send_line(8, 1);
    check("post_frame_writes", 128'(wq.size() - idx), 128'h0);
    check("frame_err_len", 128'(err_len), 128'h0);

    // Table of line lengths, each in a fresh frame.
    for (int t = 0; t < 5; t++) begin
      pulse_clear();
      vs_pulse();
      idx = wq.size();
      send_line(tbl[t].npix, 1);
      check($sformatf("tbl%0d_nwr", t), 128'(wq.size() - idx), 128'(tbl[t].nwr));
      if (wq.size() > idx) check($sformatf("tbl%0d_w0", t), wq[idx], tbl[t].w0);
      if (tbl[t].nwr > 1 && wq.size() > idx + 1) check($sformatf("tbl%0d_w1", t), wq[idx+1], tbl[t].w1);
      check($sformatf("tbl%0d_err", t), 128'(err_len), 128'(tbl[t].err));
      check($sformatf("tbl%0d_line_cnt", t), 128'(lcnt), 128'd1);
    end
    pulse_clear();
    check("err_len_cleared", 128'(err_len), 128'h0);

    // READY held low across two line ends.
    ready = 1'b0;
    vs_pulse();
    send_line(8, 1);
    check("stall_valid1", 128'(valid), 128'h1);
    check("stall_ovr1", 128'(err_ovr), 128'h0);
    send_line(8, 9);
    check("stall_valid2", 128'(valid), 128'h1);
    check("stall_ovr2", 128'(err_ovr), 128'h1);
    ready = 1'b1; tick(); ready = 1'b0;
    check("ready_drops_valid", 128'(valid), 128'h0);
    pulse_clear();
    check("ovr_cleared", 128'(err_ovr), 128'h0);
    vs_pulse();
    send_line(8, 1);
    send_pixels(8, 9);
    de = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    check("set_beats_clear_valid", 128'(valid), 128'h1);
    check("set_beats_clear_ovr", 128'(err_ovr), 128'h0);
    ready = 1'b1; tick(); tick();

    // vs fall mid-line discards the partial word.
    pulse_clear();
    vs_pulse();
    send_line(8, 1);
    idx = wq.size();
    vs = 1'b1;
    send_pixels(3, 32);
    de = 1'b0; vs = 1'b0; tick();
    check("vs_restart_frame_start", 128'(fs), 128'h1);
    check("vs_restart_line_cnt", 128'(lcnt), 128'h0);
    tick();
    check("vs_restart_no_write", 128'(wq.size() - idx), 128'h0);
    send_line(8, 16);
    check("vs_restart_word0", wq[idx], {32'h10, 32'h11, 32'h12, 32'h13});
    check("vs_restart_err", 128'(err_len), 128'h0);

    // Asynchronous reset mid-line.
    vs_pulse();
    send_line(8, 1);
    send_pixels(4, 9);
    check("pre_reset_wr_en", 128'(wr_en), 128'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_wr_en", 128'(wr_en), 128'h0);
    check("async_data", fifo_data, 128'h0);
    check("async_line_cnt", 128'(lcnt), 128'h0);
    de = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    idx = wq.size();
    send_line(8, 1);
    check("after_reset_no_write", 128'(wq.size() - idx), 128'h0);
    vs_pulse();
    send_line(8, 1);
    check("after_reset_resume", 128'(wq.size() - idx), 128'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
